// File: rtl/fibo_pkg.sv
// fibo_pkg: shared definitions for the Fibonacci generator, the inverse
// index decoder (fibo_index) and the bench reference model.
//   WIDTH_DEF   - default data width
//   IDX_W_DEF   - default index width (holds 48, the overflow index at 32b)
//   FIB_MAX_IDX - largest index whose Fibonacci value fits WIDTH_DEF bits
//   state_t     - decoder state machine encoding
package fibo_pkg;
  localparam int WIDTH_DEF   = 32;
  localparam int IDX_W_DEF   = 6;
  localparam int FIB_MAX_IDX = 47;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
endpackage

// File: rtl/fibo_index_if.sv
// fibo_index_if: start/busy/done handshake bundle for fibo_index.
//   start    - request, sampled while the decoder is not busy
//   value_in - value to classify, captured on the accepting edge
//   busy     - search in progress
//   done     - one-cycle result pulse
//   is_fib   - value_in was a Fibonacci number
//   index    - match index, or index of first Fibonacci number above value
// master = value producer, slave = decoder.
interface fibo_index_if
  import fibo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDX_W = IDX_W_DEF
);
  logic             start;
  logic [WIDTH-1:0] value_in;
  logic             busy;
  logic             done;
  logic             is_fib;
  logic [IDX_W-1:0] index;

  modport master (output start, value_in, input busy, done, is_fib, index);
  modport slave  (input start, value_in, output busy, done, is_fib, index);
endinterface

// File: rtl/fibo_index.sv
// fibo_index: inverse Fibonacci decoder. Walks the sequence one term per
// cycle (prev/cur pair) until the current term reaches or passes the
// captured target, or the next term would not fit WIDTH bits.
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - fibo_index_if slave: start/value_in in, busy/done/is_fib/index out
// All outputs are registered. Index convention: F1=1, F2=1, F3=2, ...
module fibo_index
  import fibo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  fibo_index_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] target, prev, cur;
  logic [IDX_W-1:0] idx;

  // One extra bit so the carry out of the next term is the overflow flag.
  logic [WIDTH:0]   sum;
  assign sum = {1'b0, cur} + {1'b0, prev};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      target     <= '0;
      prev       <= '0;
      cur        <= '0;
      idx        <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.is_fib <= 1'b0;
      bus.index  <= '0;
    end else begin
      case (state)
        // DONE behaves like IDLE for acceptance so back-to-back requests
        // start with no gap; done is dropped either way.
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            target     <= bus.value_in;
            prev       <= '0;
            cur        <= WIDTH'(1);
            idx        <= IDX_W'(1);
            bus.is_fib <= 1'b0;
            bus.index  <= '0;
            bus.busy   <= 1'b1;
            state      <= SEARCH;
          end else begin
            state <= IDLE;
          end
        end

        SEARCH: begin
          // Checks are ordered: zero first (the walk starts at 1), then
          // exact match, then overshoot, then overflow of the next term.
          if (target == '0) begin
            bus.is_fib <= 1'b1;
            bus.index  <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            state      <= DONE;
          end else if (cur == target) begin
            bus.is_fib <= 1'b1;
            bus.index  <= idx;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            state      <= DONE;
          end else if (cur > target) begin
            bus.is_fib <= 1'b0;
            bus.index  <= idx;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            state      <= DONE;
          end else if (sum[WIDTH]) begin
            // Next term cannot be represented: it is the first one above
            // any WIDTH-bit target, so report its index without wrapping.
            bus.is_fib <= 1'b0;
            bus.index  <= idx + 1'b1;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            state      <= DONE;
          end else begin
            prev <= cur;
            cur  <= sum[WIDTH-1:0];
            idx  <= idx + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fibo_index.sv
// tb_fibo_index: randomized and directed stimulus for fibo_index. A
// reference model predicts each request's result and latency from the
// Fibonacci sequence itself; a negedge monitor compares busy/done/is_fib/
// index every cycle, and directed cases pin the model with literals.
module tb_fibo_index;
  import fibo_pkg::*;

  typedef struct {
    bit f;
    int idx;
    int lat;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fibo_index_if #(.WIDTH(32), .IDX_W(6)) bus ();
  fibo_index    #(.WIDTH(32), .IDX_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic longint unsigned fibn(input int n);
    longint unsigned a = 0, b = 1, t;
    if (n == 0) return 0;
    for (int i = 1; i < n; i++) begin
      t = a + b; a = b; b = t;
    end
    return b;
  endfunction

  // Result from the sequence: lowest n with F_n >= t; if no 32-bit term
  // reaches t, the answer is the first unrepresentable index.
  function automatic res_t model(input logic [31:0] t);
    res_t r;
    if (t == 0) begin
      r.f = 1'b1; r.idx = 0; r.lat = 1; return r;
    end
    for (int n = 1; n <= FIB_MAX_IDX; n++) begin
      if (fibn(n) >= {32'd0, t}) begin
        r.f = (fibn(n) == {32'd0, t}); r.idx = n; r.lat = n; return r;
      end
    end
    r.f = 1'b0; r.idx = FIB_MAX_IDX + 1; r.lat = FIB_MAX_IDX;
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model, advanced on each edge ----------------
  int   cyc;
  bit   m_have;
  int   m_acc;
  res_t m_res;
  bit   r_fib;
  int   r_idx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc    <= 0;
      m_have <= 1'b0;
      m_acc  <= 0;
      m_res  <= '{1'b0, 0, 0};
      r_fib  <= 1'b0;
      r_idx  <= 0;
    end else begin
      cyc <= cyc + 1;
      if (bus.start && !(m_have && cyc + 1 <= m_acc + m_res.lat)) begin
        m_have <= 1'b1;
        m_acc  <= cyc + 1;
        m_res  <= model(bus.value_in);
        r_fib  <= 1'b0;
        r_idx  <= 0;
      end else if (m_have && cyc + 1 == m_acc + m_res.lat) begin
        r_fib <= m_res.f;
        r_idx <= m_res.idx;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("busy",   longint'(bus.busy),   longint'(m_have && cyc < m_acc + m_res.lat));
    chk("done",   longint'(bus.done),   longint'(m_have && cyc == m_acc + m_res.lat));
    chk("is_fib", longint'(bus.is_fib), longint'(r_fib));
    chk("index",  longint'(bus.index),  longint'(r_idx));
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; start is presented for exactly the next edge.
  task automatic go(input logic [31:0] v);
    bus.start    = 1'b1;
    bus.value_in = v;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Returns at the negedge where done is seen; lat counts edges from accept.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (bus.done) return;
    end
    chk("done_timeout", 0, 1);
    lat = -1;
  endtask

  task automatic lit(input string name, input logic [31:0] v,
                     input int ef, input int ei, input int el);
    int lat;
    go(v);
    wait_done(lat);
    chk({name, "_fib"}, longint'(bus.is_fib), ef);
    chk({name, "_idx"}, longint'(bus.index),  ei);
    chk({name, "_lat"}, lat, el);
  endtask

  initial begin
    int lat;
    logic [31:0] v;
    int n;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.value_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  longint'(bus.busy),   0);
    chk("rst_index", longint'(bus.index),  0);
    rst = 1'b0;
    @(negedge clk);

    // reset in the middle of a search
    go(32'd13);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy",   longint'(bus.busy),   0);
    chk("midrst_done",   longint'(bus.done),   0);
    chk("midrst_is_fib", longint'(bus.is_fib), 0);
    chk("midrst_index",  longint'(bus.index),  0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    lit("after_rst_8", 32'd8, 1, 6, 6);

    // literal pins
    @(negedge clk); lit("zero",   32'd0,          1, 0,  1);
    @(negedge clk); lit("one",    32'd1,          1, 1,  1);
    @(negedge clk); lit("thirt",  32'd13,         1, 7,  7);
    @(negedge clk); lit("fourt",  32'd14,         0, 8,  8);
    @(negedge clk); lit("four",   32'd4,          0, 5,  5);
    @(negedge clk); lit("f47",    32'd2971215073, 1, 47, 47);
    @(negedge clk); lit("allone", 32'hFFFFFFFF,   0, 48, 47);

    // start pulsed mid-search with another value is ignored
    @(negedge clk);
    go(32'd13);
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.value_in = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    chk("ign_fib", longint'(bus.is_fib), 1);
    chk("ign_idx", longint'(bus.index),  7);

    // start held through the done cycle: new search starts with no gap
    @(negedge clk);
    bus.start = 1'b1; bus.value_in = 32'd13;
    @(posedge clk);
    #1 bus.value_in = 32'd21;
    wait_done(lat);
    chk("hold1_idx", longint'(bus.index), 7);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(lat);
    chk("hold2_fib", longint'(bus.is_fib), 1);
    chk("hold2_idx", longint'(bus.index),  8);
    chk("hold2_lat", lat, 8);

    // sweep every representable index
    for (int k = 1; k <= FIB_MAX_IDX; k++) begin
      @(negedge clk);
      go(32'(fibn(k)));
      wait_done(lat);
    end

    // random mix: Fibonacci, neighbours, small and full-range values
    for (int t = 0; t < 300; t++) begin
      n = int'($urandom_range(1, FIB_MAX_IDX));
      case ($urandom_range(0, 4))
        0:       v = 32'(fibn(n));
        1:       v = 32'(fibn(n) + 1);
        2:       v = 32'(fibn(n) - 1);
        3:       v = $urandom;
        default: v = $urandom_range(0, 30);
      endcase
      // done-cycle start (no gap) half the time, else a short idle gap
      if ($urandom_range(0, 1) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clk);
      go(v);
      wait_done(lat);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fibo_index.md
# fibo_index

Inverse of the Fibonacci sequence generator: accepts a WIDTH-bit value and iteratively determines whether it is a Fibonacci number and, if so, its index. The index convention matches the generator, where index 1 ↔ 1, index 2 ↔ 1, index 3 ↔ 2, and so on. It sits downstream of value producers as a checker/decoder with a start/busy/done handshake. It uses one add-and-compare step per cycle; no lookup table.

## Interface
- WIDTH, 32, data width of the value under test
- IDX_W, 6, width of the index output; must hold the largest index reached before WIDTH-bit overflow (48 for WIDTH=32)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only when busy=0
- value_in  in  WIDTH  value to classify; sampled on the accepting edge
- busy  out  1  search in progress
- done  out  1  one-cycle pulse, result valid
- is_fib  out  1  1 = value_in is a Fibonacci number
- index  out  IDX_W  match index, or index of first Fibonacci number exceeding the target

## Operation
- State machine: IDLE → SEARCH → DONE → IDLE.
- Internal registers: target, prev, cur, and idx. prev, cur and target are WIDTH bits. idx is IDX_W bits.
- Accept:
  - Condition: start=1 while in IDLE or DONE.
  - Actions: target←value_in, prev←0, cur←1, idx←1, is_fib←0, index←0, go to SEARCH.
- SEARCH: one decision per edge, evaluated in this priority order:
  - target==0 → is_fib←1, index←0, go to DONE.
  - cur==target → is_fib←1, index←idx, go to DONE. Value 1 reports the lowest index, 1.
  - cur>target → is_fib←0, index←idx, go to DONE.
  - cur+prev carries out of WIDTH bits → is_fib←0, index←idx+1, go to DONE.
  - Otherwise → prev←cur, cur←cur+prev, idx←idx+1.
- Arithmetic: the sum is computed as WIDTH+1 bits; the carry is the overflow flag. Comparisons are unsigned.
- DONE lasts exactly one cycle, with done=1. It returns to IDLE unless start=1, which is accepted as above.
- is_fib and index hold their values from DONE until the next accepted start.
- start while in SEARCH is ignored; value_in changes during SEARCH have no effect.
- Reset (asynchronous, any state, including mid-search):
  - State goes to IDLE.
  - busy=0, done=0, is_fib=0, index=0.
  - Internal registers are cleared.

## Timing
- Start accepted at edge k.
- busy=1 from after edge k until the edge that enters DONE.
- Target 0 → done after edge k+1.
- Target F_n (n≥1, lowest n) → done after edge k+n.
- Non-Fibonacci target with F_{m-1} < target < F_m → done after edge k+m, with index=m.
- WIDTH=32:
  - Worst-case match: F_47 = 2971215073, latency 47.
  - Targets above F_47 hit overflow at idx=47 → index 48, latency 47.
- Back-to-back: start asserted during the done cycle begins a new search with no idle gap.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package fibo_pkg holds:
  - WIDTH_DEF=32, IDX_W_DEF=6, FIB_MAX_IDX=47.
  - The state typedef with members IDLE, SEARCH, DONE.
- The package is shared with the generator and with the bench reference model.
- Single module, no sub-module. The add/compare/overflow step is too small to justify a separate block.

## Test plan
- Reset mid-operation:
  - Assert rst during SEARCH for target 13 → all outputs 0 immediately.
  - After release, start with 8 → done at latency 6, index=6, is_fib=1.
- Small values:
  - 0 → is_fib=1, index=0, latency 1.
  - 1 → is_fib=1, index=1, latency 1.
  - 13 → is_fib=1, index=7, latency 7.
- Non-Fibonacci:
  - 14 → is_fib=0, index=8, latency 8.
  - 4 → is_fib=0, index=5.
- Width limits:
  - 2971215073 → is_fib=1, index=47, latency 47.
  - 0xFFFFFFFF → is_fib=0, index=48, latency 47, no wraparound false match.
- Handshake:
  - start pulsed while busy with a different value → ignored, original result reported.
  - start held through the done cycle with value 21 → new search begins immediately; next result index=8.
- Sweep: indices 1..47, checked against a software Fibonacci model.
